// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and state encoding for the SD sample streamer
package sd_pkg;

    localparam int SECTOR_BYTES       = 512;
    localparam int SAMPLES_PER_SECTOR = 256;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SPACE = 3'd1,
        S_ISSUE      = 3'd2,
        S_RECV       = 3'd3,
        S_SECT_END   = 3'd4,
        S_FINISH     = 3'd5
    } streamer_state_t;

    // Sector index to controller byte address; sectors past 2**23 alias.
    function automatic logic [31:0] sector_to_addr(input logic [31:0] sector);
        return {sector[22:0], 9'b0};
    endfunction

endpackage

// File: rtl/sd_sample_streamer_if.sv
// rtl/sd_sample_streamer_if.sv - SD controller read port between streamer and controller
interface sd_sample_streamer_if;

    logic        ready;
    logic        rd;
    logic [31:0] address;
    logic [7:0]  dout;
    logic        byte_available;

    modport master (
        input  ready,
        input  dout,
        input  byte_available,
        output rd,
        output address
    );

    modport slave (
        output ready,
        output dout,
        output byte_available,
        input  rd,
        input  address
    );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - show-ahead synchronous sample FIFO with level output
module sample_fifo #(
    parameter int AW = 10,
    parameter int W  = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          valid_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty, full, push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = level_q[AW];
    // A push into a full FIFO is only accepted when a pop frees the head slot this cycle.
    assign push_ok = push_i && (!full || pop_i);
    assign pop_ok  = pop_i && !empty;

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Next pointer and level from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) level_d = level_q + 1'b1;
        if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sd_sample_streamer.sv
// rtl/sd_sample_streamer.sv - streams SD sectors into a 16-bit sample FIFO
module sd_sample_streamer
    import sd_pkg::*;
#(
    parameter int FIFO_AW = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [31:0]          start_sector_i,
    input  logic [23:0]          num_sectors_i,
    input  logic                 stop_i,
    sd_sample_streamer_if.master sd_bus,
    input  logic                 sample_rd_i,
    output logic [15:0]          sample_out_o,
    output logic                 sample_valid_o,
    output logic [FIFO_AW:0]     fifo_level_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 underflow_o
);

    localparam logic [FIFO_AW:0] DEPTH_V = {1'b1, {FIFO_AW{1'b0}}};

    streamer_state_t state_q, state_d;
    logic [31:0]     sector_q, sector_d;
    logic [23:0]     remaining_q, remaining_d;
    logic [8:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      low_q, low_d;
    logic            push_q, push_d;
    logic [15:0]     push_data_q, push_data_d;
    logic            stop_pend_q, stop_pend_d;
    logic            underflow_q, underflow_d;
    logic            avail_q;

    logic            sd_rd, busy, sample_valid, strobe_rise, room_ok;
    logic [FIFO_AW:0] fifo_level, free_w;

    assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign strobe_rise = sd_bus.byte_available && !avail_q;
    assign free_w      = DEPTH_V - fifo_level;
    // A push still in the pipeline has not reached the level yet, so wait it out.
    assign room_ok     = (free_w >= (FIFO_AW+1)'(SAMPLES_PER_SECTOR)) && !push_q;

    assign sd_bus.rd      = sd_rd;
    assign sd_bus.address = sector_to_addr(sector_q);
    assign busy_o         = busy;
    assign done_o         = (state_q == S_FINISH);
    assign underflow_o    = underflow_q;
    assign sample_valid_o = sample_valid;
    assign fifo_level_o   = fifo_level;

    sample_fifo #(
        .AW (FIFO_AW),
        .W  (16)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (sample_rd_i),
        .data_o      (sample_out_o),
        .valid_o     (sample_valid),
        .level_o     (fifo_level)
    );

    // Run sequencing, byte packing and sticky status.
    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        remaining_d = remaining_q;
        byte_cnt_d  = byte_cnt_q;
        low_d       = low_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        stop_pend_d = stop_pend_q;
        underflow_d = underflow_q;
        sd_rd       = 1'b0;

        if (busy && stop_i) stop_pend_d = 1'b1;
        if (sample_rd_i && !sample_valid) underflow_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sector_d    = start_sector_i;
                    remaining_d = num_sectors_i;
                    underflow_d = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = (num_sectors_i == '0) ? S_FINISH : S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (stop_pend_q || remaining_q == '0) begin
                    state_d = S_FINISH;
                end else if (room_ok && sd_bus.ready) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sd_rd = 1'b1;
                if (!sd_bus.ready) begin
                    byte_cnt_d = '0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                if (strobe_rise) begin
                    if (!byte_cnt_q[0]) begin
                        low_d = sd_bus.dout;
                    end else begin
                        push_d      = 1'b1;
                        push_data_d = {sd_bus.dout, low_q};
                    end
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q == 9'(SECTOR_BYTES - 1)) state_d = S_SECT_END;
                end
            end
            S_SECT_END: begin
                if (sd_bus.ready) begin
                    sector_d    = sector_q + 32'd1;
                    remaining_d = remaining_q - 24'd1;
                    state_d     = S_WAIT_SPACE;
                end
            end
            S_FINISH: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any run in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            sector_q    <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            low_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            stop_pend_q <= 1'b0;
            underflow_q <= 1'b0;
            avail_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sector_q    <= sector_d;
            remaining_q <= remaining_d;
            byte_cnt_q  <= byte_cnt_d;
            low_q       <= low_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            stop_pend_q <= stop_pend_d;
            underflow_q <= underflow_d;
            avail_q     <= sd_bus.byte_available;
        end
    end

endmodule

// File: tb/tb_sd_sample_streamer.sv
// tb/tb_sd_sample_streamer.sv - directed scoreboard bench for sd_sample_streamer
module tb_sd_sample_streamer;
    import sd_pkg::*;

    localparam int AW = 9;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        sample_rd;
    logic [31:0] start_sector;
    logic [23:0] num_sectors;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [AW:0] fifo_level;
    logic        busy;
    logic        done;
    logic        underflow;

    sd_sample_streamer_if sd_if();

    sd_sample_streamer #(.FIFO_AW(AW)) dut (
        .clk_i          (clk),
        .reset_i        (reset_n),
        .start_i        (start),
        .start_sector_i (start_sector),
        .num_sectors_i  (num_sectors),
        .stop_i         (stop),
        .sd_bus         (sd_if),
        .sample_rd_i    (sample_rd),
        .sample_out_o   (sample_out),
        .sample_valid_o (sample_valid),
        .fifo_level_o   (fifo_level),
        .busy_o         (busy),
        .done_o         (done),
        .underflow_o    (underflow)
    );

    int total = 0;
    int bad   = 0;

    int done_cnt = 0, rd_cyc = 0, busy_cyc = 0;
    bit push_full_seen = 0;
    bit auto_pop = 0, force_pop = 0;
    int pop_target = 0, pop_done = 0, pop_cnt = 0;
    int gen = 0;
    int model_byte = -1;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] fall_log[$];

    function automatic logic [7:0] pat(input logic [31:0] a, input int i);
        return 8'((int'(a[16:9]) * 29) + i * 3 + (i / 256) * 101);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SD controller: ready drops after a read request, 512 bytes 16 clocks apart.
    initial begin
        logic [31:0] cap;
        int          my_gen;
        sd_if.ready          = 1'b1;
        sd_if.dout           = '0;
        sd_if.byte_available = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sd_if.rd === 1'b1) begin
                cap    = sd_if.address;
                my_gen = gen;
                addr_log.push_back(cap);
                repeat (2) @(posedge clk);
                #1;
                fall_log.push_back(sd_if.address);
                sd_if.ready = 1'b0;
                for (int i = 0; i < 512; i++) begin
                    repeat (14) @(posedge clk);
                    #1;
                    sd_if.dout           = pat(cap, i);
                    sd_if.byte_available = 1'b1;
                    model_byte           = i;
                    if ((i % 2) == 1 && my_gen == gen) exp_q.push_back({pat(cap, i), pat(cap, i - 1)});
                    repeat (2) @(posedge clk);
                    #1;
                    sd_if.byte_available = 1'b0;
                end
                repeat (8) @(posedge clk);
                #1;
                sd_if.ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (sd_if.rd === 1'b1) rd_cyc++;
            if (busy === 1'b1) busy_cyc++;
            if (dut.u_fifo.push_i === 1'b1 && dut.u_fifo.level_o[AW] === 1'b1) push_full_seen = 1;
        end
    end

    initial begin
        sample_rd = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (force_pop) begin
                sample_rd = 1'b1;
            end else if ((auto_pop || pop_done < pop_target) && sample_valid === 1'b1) begin
                obs_q.push_back(sample_out);
                pop_cnt++;
                if (!auto_pop) pop_done++;
                sample_rd = 1'b1;
            end else begin
                sample_rd = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [23:0] n);
        start_sector = s;
        num_sectors  = n;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(done_cnt != d0), 64'(1));
    endtask

    task automatic drain(input string tag);
        logic [15:0] o;
        logic [15:0] e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_sample observed=%0h expected=none", tag, o);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_sample"}, 64'(o), 64'(e));
            end
        end
    endtask

    initial begin
        int k, a0, d0, p0, r0, b0;
        reset_n      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        start_sector = '0;
        num_sectors  = '0;
        tick(3);
        chk("rst_rd", 64'(sd_if.rd), 64'(0));
        chk("rst_addr", 64'(sd_if.address), 64'(0));
        chk("rst_valid", 64'(sample_valid), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_underflow", 64'(underflow), 64'(0));
        chk("rst_sample_out", 64'(sample_out), 64'(0));
        reset_n = 1'b1;
        tick(2);

        // Two sectors from sector 5 with a consumer that pops whenever data is present.
        auto_pop = 1;
        a0 = addr_log.size(); d0 = done_cnt; p0 = pop_cnt;
        pulse_start(32'd5, 24'd2);
        wait_done(20000, "t1_done_seen");
        tick(5);
        chk("t1_nreads", 64'(addr_log.size() - a0), 64'(2));
        if (addr_log.size() >= a0 + 2) begin
            chk("t1_addr0", 64'(addr_log[a0]), 64'h0A00);
            chk("t1_addr1", 64'(addr_log[a0 + 1]), 64'h0C00);
        end
        chk("t1_pops", 64'(pop_cnt - p0), 64'(512));
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
        if (obs_q.size() > 0) chk("t1_first_sample", 64'(obs_q[0]), 64'({pat(32'h0A00, 1), pat(32'h0A00, 0)}));
        drain("t1");
        chk("t1_exp_left", 64'(exp_q.size()), 64'(0));
        chk("t1_busy_after", 64'(busy), 64'(0));

        // Empty run: immediate done, no read request.
        auto_pop = 0;
        r0 = rd_cyc; b0 = busy_cyc; d0 = done_cnt;
        pulse_start(32'd9, 24'd0);
        wait_done(4, "t2_done_seen");
        tick(2);
        chk("t2_no_rd", 64'(rd_cyc - r0), 64'(0));
        chk("t2_busy_short", 64'((busy_cyc - b0) <= 2), 64'(1));
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Pop on an empty FIFO.
        force_pop = 1;
        tick(1);
        force_pop = 0;
        chk("t5_underflow_set", 64'(underflow), 64'(1));
        chk("t5_level_empty", 64'(fifo_level), 64'(0));
        chk("t5_valid_empty", 64'(sample_valid), 64'(0));
        tick(2);

        // No consumer: two sectors fill a 512-deep FIFO and the run stalls.
        a0 = addr_log.size();
        pulse_start(32'd100, 24'd4);
        chk("t5_underflow_cleared", 64'(underflow), 64'(0));
        chk("t3_busy", 64'(busy), 64'(1));
        k = 0;
        while (fifo_level != 10'd512 && k < 20000) begin tick(1); k++; end
        chk("t3_fill_reached", 64'(fifo_level == 10'd512), 64'(1));
        tick(300);
        chk("t3_two_reads", 64'(addr_log.size() - a0), 64'(2));
        chk("t3_level_full", 64'(fifo_level), 64'(512));
        chk("t3_state_wait", 64'(dut.state_q), 64'(S_WAIT_SPACE));
        pop_target = pop_target + 256;
        k = 0;
        while (pop_done != pop_target && k < 600) begin tick(1); k++; end
        chk("t3_pops_done", 64'(pop_done == pop_target), 64'(1));
        k = 0;
        while (addr_log.size() < a0 + 3 && k < 200) begin tick(1); k++; end
        chk("t3_third_read", 64'(addr_log.size() - a0), 64'(3));
        if (addr_log.size() >= a0 + 3) chk("t3_addr2", 64'(addr_log[a0 + 2]), 64'h0000_CC00);
        drain("t3");

        // Reset in the middle of the third sector.
        k = 0;
        while (model_byte != 100 && k < 3000) begin tick(1); k++; end
        chk("t6_reached_recv", 64'(model_byte), 64'(100));
        reset_n = 1'b0;
        gen++;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_level", 64'(fifo_level), 64'(0));
        chk("t6_rst_valid", 64'(sample_valid), 64'(0));
        chk("t6_rst_rd", 64'(sd_if.rd), 64'(0));
        chk("t6_rst_addr", 64'(sd_if.address), 64'(0));
        exp_q.delete();
        obs_q.delete();
        tick(3);
        reset_n = 1'b1;
        a0 = addr_log.size();
        k = 0;
        while (sd_if.ready !== 1'b1 && k < 9000) begin tick(1); k++; end
        chk("t6_ready_back", 64'(sd_if.ready), 64'(1));
        tick(20);
        chk("t6_trailing_level", 64'(fifo_level), 64'(0));
        chk("t6_no_reissue", 64'(addr_log.size() - a0), 64'(0));

        // Fresh single-sector run; push and pop coincide at level 1.
        a0 = addr_log.size(); d0 = done_cnt; p0 = pop_cnt;
        pulse_start(32'd7, 24'd1);
        k = 0;
        while (fifo_level != 10'd1 && k < 400) begin tick(1); k++; end
        chk("t5_level_one", 64'(fifo_level), 64'(1));
        k = 0;
        while (!(sd_if.byte_available === 1'b1 && model_byte == 3) && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        @(posedge clk); #1;
        pop_target = pop_target + 1;
        tick(1);
        chk("t5_pushpop_level", 64'(fifo_level), 64'(1));
        chk("t5_pushpop_head", 64'(sample_out), 64'({pat(32'h0E00, 3), pat(32'h0E00, 2)}));
        auto_pop = 1;
        wait_done(10000, "t6_fresh_done_seen");
        tick(5);
        chk("t6_fresh_nreads", 64'(addr_log.size() - a0), 64'(1));
        if (addr_log.size() >= a0 + 1) chk("t6_fresh_addr", 64'(addr_log[a0]), 64'h0E00);
        chk("t6_fresh_pops", 64'(pop_cnt - p0), 64'(256));
        chk("t6_fresh_done_pulses", 64'(done_cnt - d0), 64'(1));
        drain("t6");
        chk("t6_exp_left", 64'(exp_q.size()), 64'(0));

        // Stop partway through the first of three sectors.
        a0 = addr_log.size(); d0 = done_cnt; p0 = pop_cnt;
        pulse_start(32'd20, 24'd3);
        k = 0;
        while (model_byte != 200 && k < 6000) begin tick(1); k++; end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_done(10000, "t4_done_seen");
        r0 = rd_cyc;
        tick(100);
        chk("t4_no_more_rd", 64'(rd_cyc - r0), 64'(0));
        chk("t4_nreads", 64'(addr_log.size() - a0), 64'(1));
        if (addr_log.size() >= a0 + 1) chk("t4_addr", 64'(addr_log[a0]), 64'h2800);
        chk("t4_pops", 64'(pop_cnt - p0), 64'(256));
        chk("t4_done_pulses", 64'(done_cnt - d0), 64'(1));
        drain("t4");
        chk("t4_exp_left", 64'(exp_q.size()), 64'(0));

        chk("push_while_full", 64'(push_full_seen), 64'(0));
        chk("addr_stable_count", 64'(fall_log.size()), 64'(addr_log.size()));
        for (int i = 0; i < fall_log.size() && i < addr_log.size(); i++) begin
            chk("addr_stable", 64'(fall_log[i]), 64'(addr_log[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
